i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h48, the 7-bit target address this block acknowledges.
REQ-002 Parameter: FILT_LEN, default 3, the number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
REQ-003 Port: clk, input, 1, system clock; SHALL be at least 20x the SCL frequency.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: scl_i, input, 1, SCL pin level.
REQ-006 Port: sda_i, input, 1, SDA pin level.
REQ-007 Port: sda_oe, output, 1, 1 = pull SDA low, 0 = release; the block never drives SDA high.
REQ-008 Port: rx_data, output, 8, last byte written by the controller.
REQ-009 Port: rx_valid, output, 1, one-cycle pulse marking rx_data as updated.
REQ-010 Port: tx_req, output, 1, one-cycle pulse requesting the next read byte.
REQ-011 Port: tx_data, input, 8, read byte; sampled in the cycle tx_req=1.
REQ-012 Port: busy, output, 1, high from an addressed START until STOP.

Function
REQ-013 scl_i/sda_i SHALL pass a 2-FF synchronizer, then a FILT_LEN-sample glitch filter; all decisions use the filtered levels.
REQ-014 START = filtered SDA 1->0 while filtered SCL=1; STOP = SDA 0->1 while SCL=1; each is detected in every state, including mid-byte.
REQ-015 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACKCHK, IGNORE.
REQ-016 SDA is sampled on the filtered SCL rising edge; sda_oe changes only on the filtered SCL falling edge, reset excepted.
REQ-017 START from any state -> ADDR with the bit counter cleared (repeated START supported).
REQ-018 STOP from any state -> IDLE with sda_oe=0 and busy=0.
REQ-019 ADDR shifts 8 bits MSB first (7-bit address, then R/W).
- On match after the 8th rise: ADDR_ACK, busy=1, and sda_oe=1 from the next SCL fall until the following SCL fall.
- On mismatch, including general call 7'h00: IGNORE, and sda_oe stays 0 until START/STOP.
REQ-020 Write (R/W=0): after ACK -> RX_BYTE.
- On the 8th rise, rx_data updates and rx_valid pulses in the same cycle.
- RX_ACK then drives ACK for one SCL low/high period exactly as in ADDR_ACK, and returns to RX_BYTE.
REQ-021 Read (R/W=1): on the SCL fall that ends the address ACK, tx_req pulses, tx_data loads into the shift register, and sda_oe = ~bit7.
- On each subsequent fall, the next bit is presented.
- After the 8th bit's fall, sda_oe=0 (TX_ACKCHK).
REQ-022 In TX_ACKCHK, SDA sampled on the rise:
- 0 (ACK): the next fall repeats REQ-021 (new tx_req, next byte).
- 1 (NACK): IGNORE with SDA released.
REQ-023 rx_valid and tx_req are never high in the same cycle and never high for more than one cycle.
REQ-024 sda_oe SHALL follow an SCL pin fall within FILT_LEN+4 clk cycles.
REQ-025 SCL activity without a preceding START SHALL leave the state in IDLE with all outputs quiescent.

Reset
REQ-026 While rst=1, asynchronously: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, counters and shift register cleared, filters preset to 1 (idle bus).
REQ-027 Reset mid-transfer SHALL release SDA immediately; after rst deasserts, the block ignores the bus until the next START.

Verification
REQ-028 Write 0x90,0xA5,STOP -> ACK on both bytes; rx_data=8'hA5 with one rx_valid pulse; busy falls after STOP.
REQ-029 Read 0x91, tx_data=8'h3C, controller ACK, tx_data=8'hC3, controller NACK, STOP -> SDA bits 00111100 then 11000011; exactly two tx_req pulses; sda_oe=0 after NACK.
REQ-030 Address 0xA0 and general call 0x00 -> no ACK (SDA high on the 9th clock); no rx_valid/tx_req; busy=0.
REQ-031 Write 0x90,0x11, repeated START, 0x91, read one byte -> rx_data=8'h11, then a correct read byte with no STOP in between.
REQ-032 SDA glitch of FILT_LEN-1 clk cycles while SCL high -> no START/STOP detected.
REQ-033 rst pulsed during the 4th data bit of a read -> sda_oe=0 in the same cycle; no ACK until a new START with address 0x90/0x91.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target: synchronised, glitch-filtered SCL/SDA front end and a byte-level FSM
// that ACKs its address, receives write bytes and serves read bytes on request.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// ADDR       | shifting address + R/W bit
// ADDR_ACK   | driving ACK for a matched address
// RX_BYTE    | shifting a write byte from the controller
// RX_ACK     | driving ACK for a received byte
// TX_BYTE    | presenting read-byte bits on SCL falls
// TX_ACKCHK  | sampling the controller ACK/NACK
// IGNORE     | not addressed or NACKed, wait for START/STOP
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] FILT_LOAD = CW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACKCHK, IGNORE
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f, scl_d, sda_d;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    rx_data_n;
    logic          rw, rw_n, acked, acked_n;
    logic          sda_oe_n, rx_valid_n, busy_n;

    // A new level is accepted only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_cnt  <= FILT_LOAD;
            sda_cnt  <= FILT_LOAD;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= FILT_LOAD;
            end else if (scl_cnt == '0) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= FILT_LOAD;
            end else begin
                scl_cnt <= scl_cnt - 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= FILT_LOAD;
            end else if (sda_cnt == '0) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= FILT_LOAD;
            end else begin
                sda_cnt <= sda_cnt - 1'b1;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            rw       <= 1'b0;
            acked    <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            rw       <= rw_n;
            acked    <= acked_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rw_n       = rw;
        acked_n    = acked;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        busy_n     = busy;
        tx_req     = 1'b0;
        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_n   = {shreg[6:0], sda_f};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shreg[6:0] == DEV_ADDR && DEV_ADDR != 7'h00) begin
                            state_n = ADDR_ACK;
                            busy_n  = 1'b1;
                            rw_n    = sda_f;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                // sda_oe doubles as the phase flag: first fall drives ACK, second releases it.
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 3'd0;
                        if (state == RX_ACK || !rw) begin
                            state_n = RX_BYTE;
                        end else begin
                            tx_req   = 1'b1;
                            shreg_n  = tx_data;
                            sda_oe_n = ~tx_data[7];
                            state_n  = TX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shreg_n   = {shreg[6:0], sda_f};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_n  = {shreg[6:0], sda_f};
                        rx_valid_n = 1'b1;
                        state_n    = RX_ACK;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        sda_oe_n = 1'b0;
                        acked_n  = 1'b0;
                        state_n  = TX_ACKCHK;
                    end else begin
                        shreg_n   = {shreg[6:0], 1'b0};
                        sda_oe_n  = ~shreg[6];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                TX_ACKCHK: begin
                    if (scl_rise) begin
                        if (sda_f) state_n = IGNORE;
                        else       acked_n = 1'b1;
                    end else if (scl_fall && acked) begin
                        tx_req    = 1'b1;
                        shreg_n   = tx_data;
                        sda_oe_n  = ~tx_data[7];
                        bit_cnt_n = 3'd0;
                        state_n   = TX_BYTE;
                    end
                end
                IDLE, IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
